axi_slave_rr_arbiter: RTL

//  Per-slave round-robin arbiter for the AXI interconnect, generalised to NUM_MASTERS x NUM_SLAVES.

---
 rtl/axi_arb_pkg.sv | 25 ++
 rtl/arb_rr_pick.sv | 43 ++++
 rtl/axi_slave_rr_arbiter.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// ---------------------------------------------------------------------------
// axi_arb_pkg
//   Shared types and helpers for the per-slave round-robin AXI arbiter.
//   - arb_state_e      : per-slave lock state (IDLE / BUSY)
//   - clog2_min1       : $clog2 that never returns 0, for index widths
//   - arb_target_vec_t : packed per-master target vector for the default
//                        3-master x 6-slave build (master 0 in the LSBs)
// ---------------------------------------------------------------------------
package axi_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int ARB_NM_DEFAULT = 3;
    localparam int ARB_NS_DEFAULT = 6;

    typedef logic [ARB_NM_DEFAULT*clog2_min1(ARB_NS_DEFAULT)-1:0] arb_target_vec_t;

endpackage

// File: rtl/arb_rr_pick.sv
// ---------------------------------------------------------------------------
// arb_rr_pick
//   Combinational round-robin picker. Searches the request vector starting
//   at the position just after ptr_i, wrapping modulo N, and returns the
//   first requester both one-hot and as an index.
// Ports
//   req_i  in  N    request per master
//   ptr_i  in  IW   index of the last winner
//   gnt_o  out N    one-hot winner (all zero when no request)
//   idx_o  out IW   winner index (0 when no request)
// ---------------------------------------------------------------------------
module arb_rr_pick
    import axi_arb_pkg::*;
#(
    parameter  int N  = 3,
    localparam int IW = clog2_min1(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o
);

    always_comb begin
        int   cand;
        logic found;
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        // i = N lands back on the pointer itself, so the last winner is
        // considered only after everyone else.
        for (int i = 1; i <= N; i++) begin
            cand = (int'(ptr_i) + i) % N;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axi_slave_rr_arbiter.sv
// ---------------------------------------------------------------------------
// axi_slave_rr_arbiter
//   Per-slave round-robin arbiter for an NUM_MASTERS x NUM_SLAVES AXI
//   interconnect. Every slave port owns an independent IDLE/BUSY lock so
//   transactions to different slaves overlap. Grants are registered to break
//   the valid->ready combinational path through the crossbar.
//
//   Handshake: a master requests a slave by holding req_valid_i with its
//   decoded target; the grant appears one edge later and is held until
//   release_i for that slave is seen (release_i is ignored while IDLE).
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     defined   : per-slave BUSY counter; after TIMEOUT_CYCLES BUSY cycles
//                 without release the lock is dropped and timeout_o pulses.
//     undefined : no counters, timeout_o tied 0, locks held indefinitely.
//
// Ports
//   ACLK            in   1       clock
//   ARESETn         in   1       asynchronous active-low reset
//   req_valid_i     in   NM      ARVALID|AWVALID per master
//   req_target_i    in   NM*SW   decoded slave index per master (m0 in LSBs)
//   release_i       in   NS      per-slave end-of-transaction strobe
//   grant_valid_o   out  NS      slave s locked to a master
//   grant_master_o  out  NS*MW   owning master per slave (s0 in LSBs)
//   master_busy_o   out  NM      master currently holds some slave
//   timeout_o       out  NS      one-cycle pulse on forced release
// ---------------------------------------------------------------------------
module axi_slave_rr_arbiter
    import axi_arb_pkg::*;
#(
    parameter  int NUM_MASTERS    = 3,
    parameter  int NUM_SLAVES     = 6,
    parameter  int DEFAULT_SLAVE  = 5,
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int MW             = clog2_min1(NUM_MASTERS),
    localparam int SW             = clog2_min1(NUM_SLAVES)
) (
    input  logic                      ACLK,
    input  logic                      ARESETn,
    input  logic [NUM_MASTERS-1:0]    req_valid_i,
    input  logic [NUM_MASTERS*SW-1:0] req_target_i,
    input  logic [NUM_SLAVES-1:0]     release_i,
    output logic [NUM_SLAVES-1:0]     grant_valid_o,
    output logic [NUM_SLAVES*MW-1:0]  grant_master_o,
    output logic [NUM_MASTERS-1:0]    master_busy_o,
    output logic [NUM_SLAVES-1:0]     timeout_o
);

    if (NUM_MASTERS < 2 || NUM_SLAVES < 2 || TIMEOUT_CYCLES < 2 ||
        DEFAULT_SLAVE < 0 || DEFAULT_SLAVE >= NUM_SLAVES) begin : g_bad_param
        $error("axi_slave_rr_arbiter: illegal parameter combination");
    end

    // Widened so the comparison also works when NUM_SLAVES is a power of two.
    localparam logic [SW:0] NS_LIMIT = (SW+1)'(NUM_SLAVES);

    logic [SW-1:0]          tgt      [NUM_MASTERS];
    logic [NUM_MASTERS-1:0] pick_req [NUM_SLAVES];
    logic [NUM_MASTERS-1:0] pick_gnt [NUM_SLAVES];
    logic [MW-1:0]          pick_idx [NUM_SLAVES];

    arb_state_e             state_q        [NUM_SLAVES];
    arb_state_e             state_d        [NUM_SLAVES];
    logic [MW-1:0]          ptr_q          [NUM_SLAVES];
    logic [MW-1:0]          ptr_d          [NUM_SLAVES];
    logic [MW-1:0]          grant_master_q [NUM_SLAVES];
    logic [MW-1:0]          grant_master_d [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]  grant_valid_q,  grant_valid_d;
    logic [NUM_MASTERS-1:0] master_busy_q,  master_busy_d;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = clog2_min1(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0]          cnt_q [NUM_SLAVES];
    logic [CW-1:0]          cnt_d [NUM_SLAVES];
    logic [NUM_SLAVES-1:0]  timeout_q, timeout_d;
`endif

    // Target decode: out-of-range targets go to the decode-error slave.
    // A master already holding a slave is excluded from every slave's pick,
    // which is what keeps a master to at most one grant.
    always_comb begin
        logic [SW-1:0] raw;
        raw = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            raw    = req_target_i[m*SW +: SW];
            tgt[m] = ({1'b0, raw} >= NS_LIMIT) ? SW'(DEFAULT_SLAVE) : raw;
        end
        for (int s = 0; s < NUM_SLAVES; s++) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                pick_req[s][m] = req_valid_i[m] & ~master_busy_q[m] & (tgt[m] == SW'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_SLAVES; s++) begin : g_slave
        arb_rr_pick #(
            .N (NUM_MASTERS)
        ) u_pick (
            .req_i (pick_req[s]),
            .ptr_i (ptr_q[s]),
            .gnt_o (pick_gnt[s]),
            .idx_o (pick_idx[s])
        );

        assign grant_master_o[s*MW +: MW] = grant_master_q[s];
    end

    // Per-slave lock next state.
    always_comb begin
        for (int s = 0; s < NUM_SLAVES; s++) begin
            state_d[s]        = state_q[s];
            ptr_d[s]          = ptr_q[s];
            grant_valid_d[s]  = grant_valid_q[s];
            grant_master_d[s] = grant_master_q[s];
`ifdef ARB_TIMEOUT_EN
            cnt_d[s]          = cnt_q[s];
            timeout_d[s]      = 1'b0;
`endif
            case (state_q[s])
                ARB_IDLE: begin
                    if (|pick_gnt[s]) begin
                        state_d[s]        = ARB_BUSY;
                        grant_valid_d[s]  = 1'b1;
                        grant_master_d[s] = pick_idx[s];
                        ptr_d[s]          = pick_idx[s];
`ifdef ARB_TIMEOUT_EN
                        cnt_d[s]          = '0;
`endif
                    end
                end
                ARB_BUSY: begin
                    if (release_i[s]) begin
                        state_d[s]        = ARB_IDLE;
                        grant_valid_d[s]  = 1'b0;
                        grant_master_d[s] = '0;
                    end
`ifdef ARB_TIMEOUT_EN
                    // A genuine release in the final cycle takes priority
                    // and suppresses the timeout pulse.
                    else if (cnt_q[s] == CNT_LAST) begin
                        state_d[s]        = ARB_IDLE;
                        grant_valid_d[s]  = 1'b0;
                        grant_master_d[s] = '0;
                        timeout_d[s]      = 1'b1;
                    end else begin
                        cnt_d[s]          = cnt_q[s] + 1'b1;
                    end
`endif
                end
                default: begin
                    state_d[s]        = ARB_IDLE;
                    grant_valid_d[s]  = 1'b0;
                    grant_master_d[s] = '0;
                end
            endcase
        end

        // Busy is derived from the next grant state so that master_busy_o
        // always agrees with grant_valid_o/grant_master_o in the same cycle.
        for (int m = 0; m < NUM_MASTERS; m++) begin
            master_busy_d[m] = 1'b0;
            for (int s = 0; s < NUM_SLAVES; s++) begin
                if (grant_valid_d[s] && (grant_master_d[s] == MW'(m))) begin
                    master_busy_d[m] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                state_q[s]        <= ARB_IDLE;
                ptr_q[s]          <= MW'(NUM_MASTERS - 1);
                grant_master_q[s] <= '0;
`ifdef ARB_TIMEOUT_EN
                cnt_q[s]          <= '0;
`endif
            end
            grant_valid_q <= '0;
            master_busy_q <= '0;
`ifdef ARB_TIMEOUT_EN
            timeout_q     <= '0;
`endif
        end else begin
            for (int s = 0; s < NUM_SLAVES; s++) begin
                state_q[s]        <= state_d[s];
                ptr_q[s]          <= ptr_d[s];
                grant_master_q[s] <= grant_master_d[s];
`ifdef ARB_TIMEOUT_EN
                cnt_q[s]          <= cnt_d[s];
`endif
            end
            grant_valid_q <= grant_valid_d;
            master_busy_q <= master_busy_d;
`ifdef ARB_TIMEOUT_EN
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign grant_valid_o = grant_valid_q;
    assign master_busy_o = master_busy_q;

`ifdef ARB_TIMEOUT_EN
    assign timeout_o = timeout_q;
`else
    assign timeout_o = '0;
`endif

endmodule
